// File: rtl/iob_pkg.sv
// Shared types and helpers for the IO bus write-posting queue.
package iob_pkg;

  localparam int IOB_AW = 23;
  localparam int IOB_DW = 16;

  // One queued bus access in the default configuration.
  typedef struct packed {
    logic [IOB_AW-1:0] addr;
    logic [IOB_DW-1:0] data;
    logic              rw;
    logic              l;
    logic              u;
  } iob_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACT  = 2'd2
  } iob_state_t;

  // Ceiling log2 for sizing pointers from DEPTH.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/iob_ring_buf.sv
// Circular entry storage; head is read combinationally, push writes at tail.
module iob_ring_buf
  import iob_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = iob_entry_t
) (
  input  logic   i_clk_sys,
  input  logic   i_rst_b,
  input  logic   i_push,
  input  entry_t i_wdata,
  input  logic   i_pop,
  output entry_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int          PW       = clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  entry_t        r_mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk_sys or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; outputs are qualified by the count instead.
  always_ff @(posedge i_clk_sys) begin
    if (i_push) r_mem[r_tail] <= i_wdata;
  end

  assign o_head  = r_mem[r_head];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/iobs_post_queue.sv
// IO bus slave write-posting queue between FSB AS decode and the IO bus master.
//
// state | meaning
// IDLE  | no transfer in progress; leaves when the queue holds an entry
// REQ   | IOREQ high, waiting for the master to raise IOACT
// ACT   | master busy with the head entry; pops it when IOACT falls
module iobs_post_queue
  import iob_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int AW          = 23,
  parameter int DW          = 16,
  parameter int ENABLE_POST = 1
) (
  input  logic          CLK_FSB,
  input  logic          nRES,
  input  logic          ASActive,
  input  logic          ASInactive,
  input  logic          IOCS,
  input  logic          nWE_FSB,
  input  logic          nLDS_FSB,
  input  logic          nUDS_FSB,
  input  logic [AW-1:0] A_FSB,
  input  logic [DW-1:0] D_FSB,
  output logic          Ready,
  output logic [DW-1:0] RdData,
  output logic          IOREQ,
  input  logic          IOACT,
  output logic [AW-1:0] IOA,
  output logic [DW-1:0] IOD,
  output logic          IORW,
  output logic          IOL,
  output logic          IOU,
  input  logic [DW-1:0] IORdD,
  output logic          Full,
  output logic          Empty
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rw;
    logic          l;
    logic          u;
  } entry_t;

  iob_state_t    r_state;
  logic          r_ioreq;
  logic          r_ready;
  logic          r_accepted;
  logic          r_wait_pop;
  logic [DW-1:0] r_rddata;

  logic   w_ds;
  logic   w_wait_empty;
  logic   w_room;
  logic   w_take;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;
  entry_t w_wr_entry;
  entry_t w_head;

  // Reads and non-posted writes only enter an empty queue, so the next pop
  // is always their own entry.
  assign w_ds         = ~nLDS_FSB | ~nUDS_FSB;
  assign w_wait_empty = nWE_FSB | (ENABLE_POST == 0);
  assign w_room       = w_wait_empty ? w_empty : ~w_full;
  assign w_take       = ASActive & IOCS & w_ds & ~r_accepted & w_room;
  assign w_pop        = (r_state == ACT) & ~IOACT;
  assign w_wr_entry   = {A_FSB, D_FSB, nWE_FSB, ~nLDS_FSB, ~nUDS_FSB};

  iob_ring_buf #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ring (
    .i_clk_sys (CLK_FSB),
    .i_rst_b   (nRES),
    .i_push    (w_take),
    .i_wdata   (w_wr_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // FSB side: one enqueue per AS, Ready completion and read data capture.
  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      r_accepted <= 1'b0;
      r_ready    <= 1'b1;
      r_wait_pop <= 1'b0;
      r_rddata   <= '0;
    end else begin
      if (w_pop && w_head.rw) r_rddata <= IORdD;
      if (ASInactive) begin
        r_accepted <= 1'b0;
        r_ready    <= 1'b1;
        r_wait_pop <= 1'b0;
      end else if (!IOCS) begin
        r_ready <= 1'b1;
      end else if (ASActive) begin
        if (w_take) begin
          r_accepted <= 1'b1;
          r_ready    <= ~w_wait_empty;
          r_wait_pop <= w_wait_empty;
        end else if (r_wait_pop && w_pop) begin
          r_ready    <= 1'b1;
          r_wait_pop <= 1'b0;
        end else if (!r_accepted) begin
          r_ready <= 1'b0;
        end
      end
    end
  end

  // Master handshake FSM with registered IOREQ.
  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      r_state <= IDLE;
      r_ioreq <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (!w_empty) begin
          r_state <= REQ;
          r_ioreq <= 1'b1;
        end
        REQ: if (IOACT) begin
          r_state <= ACT;
          r_ioreq <= 1'b0;
        end
        ACT: if (!IOACT) r_state <= IDLE;
        default: begin
          r_state <= IDLE;
          r_ioreq <= 1'b0;
        end
      endcase
    end
  end

  assign Ready  = r_ready;
  assign RdData = r_rddata;
  assign IOREQ  = r_ioreq;
  assign Full   = w_full;
  assign Empty  = w_empty;
  assign IOA    = w_empty ? '0 : w_head.addr;
  assign IOD    = w_empty ? '0 : w_head.data;
  assign IORW   = w_empty ? 1'b0 : w_head.rw;
  assign IOL    = w_empty ? 1'b0 : w_head.l;
  assign IOU    = w_empty ? 1'b0 : w_head.u;

endmodule

// File: tb/tb_iobs_post_queue.sv
// Directed bench: three queue configurations share one FSB/master stimulus;
// each phase checks the instance selected by sel.
module tb_iobs_post_queue;

  typedef struct packed {
    logic        ready;
    logic [15:0] rddata;
    logic        ioreq;
    logic [22:0] ioa;
    logic [15:0] iod;
    logic        iorw;
    logic        iol;
    logic        iou;
    logic        full;
    logic        empty;
  } obs_t;

  logic        clk;
  logic        nRES;
  logic        ASActive, ASInactive, IOCS, nWE_FSB, nLDS_FSB, nUDS_FSB;
  logic [22:0] A_FSB;
  logic [15:0] D_FSB;
  logic        IOACT;
  logic [15:0] IORdD;

  obs_t o_d2, o_np, o_d4, m;
  logic [1:0] sel;
  int total = 0;
  int bad   = 0;

  iobs_post_queue #(.DEPTH(2), .ENABLE_POST(1)) u_d2 (
    .CLK_FSB(clk), .nRES(nRES), .ASActive(ASActive), .ASInactive(ASInactive),
    .IOCS(IOCS), .nWE_FSB(nWE_FSB), .nLDS_FSB(nLDS_FSB), .nUDS_FSB(nUDS_FSB),
    .A_FSB(A_FSB), .D_FSB(D_FSB), .Ready(o_d2.ready), .RdData(o_d2.rddata),
    .IOREQ(o_d2.ioreq), .IOACT(IOACT), .IOA(o_d2.ioa), .IOD(o_d2.iod),
    .IORW(o_d2.iorw), .IOL(o_d2.iol), .IOU(o_d2.iou), .IORdD(IORdD),
    .Full(o_d2.full), .Empty(o_d2.empty));

  iobs_post_queue #(.DEPTH(2), .ENABLE_POST(0)) u_np (
    .CLK_FSB(clk), .nRES(nRES), .ASActive(ASActive), .ASInactive(ASInactive),
    .IOCS(IOCS), .nWE_FSB(nWE_FSB), .nLDS_FSB(nLDS_FSB), .nUDS_FSB(nUDS_FSB),
    .A_FSB(A_FSB), .D_FSB(D_FSB), .Ready(o_np.ready), .RdData(o_np.rddata),
    .IOREQ(o_np.ioreq), .IOACT(IOACT), .IOA(o_np.ioa), .IOD(o_np.iod),
    .IORW(o_np.iorw), .IOL(o_np.iol), .IOU(o_np.iou), .IORdD(IORdD),
    .Full(o_np.full), .Empty(o_np.empty));

  iobs_post_queue #(.DEPTH(4), .ENABLE_POST(1)) u_d4 (
    .CLK_FSB(clk), .nRES(nRES), .ASActive(ASActive), .ASInactive(ASInactive),
    .IOCS(IOCS), .nWE_FSB(nWE_FSB), .nLDS_FSB(nLDS_FSB), .nUDS_FSB(nUDS_FSB),
    .A_FSB(A_FSB), .D_FSB(D_FSB), .Ready(o_d4.ready), .RdData(o_d4.rddata),
    .IOREQ(o_d4.ioreq), .IOACT(IOACT), .IOA(o_d4.ioa), .IOD(o_d4.iod),
    .IORW(o_d4.iorw), .IOL(o_d4.iol), .IOU(o_d4.iou), .IORdD(IORdD),
    .Full(o_d4.full), .Empty(o_d4.empty));

  always_comb begin
    case (sel)
      2'd1:    m = o_np;
      2'd2:    m = o_d4;
      default: m = o_d2;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nRES  = 1'b0;
    IOACT = 1'b0;
    tick();
    tick();
    nRES = 1'b1;
    tick();
  endtask

  // First AS cycle with data strobes still inactive.
  task automatic as_start(input logic rd, input logic [22:0] a, input logic [15:0] d);
    ASActive   = 1'b1;
    ASInactive = 1'b0;
    IOCS       = 1'b1;
    nWE_FSB    = rd;
    A_FSB      = a;
    D_FSB      = d;
    nLDS_FSB   = 1'b1;
    nUDS_FSB   = 1'b1;
    tick();
  endtask

  task automatic ds_on(input logic l, input logic u);
    nLDS_FSB = ~l;
    nUDS_FSB = ~u;
  endtask

  task automatic as_end();
    ASActive   = 1'b0;
    ASInactive = 1'b1;
    nLDS_FSB   = 1'b1;
    nUDS_FSB   = 1'b1;
    tick();
    ASInactive = 1'b0;
    tick();
  endtask

  task automatic post_write(input logic [22:0] a, input logic [15:0] d);
    as_start(1'b0, a, d);
    ds_on(1'b1, 1'b1);
    tick();
    as_end();
  endtask

  // Acts as the IO bus master for one entry; returns just after the pop edge.
  task automatic serve(input string tag, input logic rw, input logic [22:0] a,
                       input logic [15:0] d, input logic l, input logic u,
                       input logic [15:0] rd);
    int n;
    n = 0;
    while (!m.ioreq && n < 50) begin
      tick();
      n++;
    end
    check_b({tag, "_ioreq"}, m.ioreq, 1'b1);
    check_v({tag, "_ioa"}, 32'(m.ioa), 32'(a));
    check_v({tag, "_iod"}, 32'(m.iod), 32'(d));
    check_b({tag, "_iorw"}, m.iorw, rw);
    check_b({tag, "_iol"}, m.iol, l);
    check_b({tag, "_iou"}, m.iou, u);
    IOACT = 1'b1;
    tick();
    IOACT = 1'b0;
    IORdD = rd;
    tick();
    IORdD = 16'h0000;
  endtask

  initial begin
    sel        = 2'd0;
    nRES       = 1'b0;
    ASActive   = 1'b0;
    ASInactive = 1'b0;
    IOCS       = 1'b0;
    nWE_FSB    = 1'b1;
    nLDS_FSB   = 1'b1;
    nUDS_FSB   = 1'b1;
    A_FSB      = '0;
    D_FSB      = '0;
    IOACT      = 1'b0;
    IORdD      = '0;

    // Reset values
    tick();
    tick();
    check_b("rst_ready", m.ready, 1'b1);
    check_b("rst_ioreq", m.ioreq, 1'b0);
    check_v("rst_rddata", 32'(m.rddata), 32'h0);
    check_b("rst_empty", m.empty, 1'b1);
    check_b("rst_full", m.full, 1'b0);
    check_v("rst_ioa", 32'(m.ioa), 32'h0);
    check_b("rst_iorw", m.iorw, 1'b0);
    nRES = 1'b1;
    tick();

    // T1: DEPTH=2 posting, master idle; third write blocks on Full
    as_start(1'b0, 23'h2C0000, 16'h1111);
    check_b("t1_w1_wait", m.ready, 1'b0);
    ds_on(1'b1, 1'b1);
    tick();
    check_b("t1_w1_ready", m.ready, 1'b1);
    check_b("t1_w1_empty", m.empty, 1'b0);
    as_end();
    as_start(1'b0, 23'h2C0001, 16'h2222);
    ds_on(1'b1, 1'b1);
    tick();
    check_b("t1_w2_ready", m.ready, 1'b1);
    check_b("t1_w2_full", m.full, 1'b1);
    check_b("t1_ioreq", m.ioreq, 1'b1);
    check_v("t1_head", 32'(m.ioa), 32'h2C0000);
    as_end();
    as_start(1'b0, 23'h2C0002, 16'h3333);
    ds_on(1'b1, 1'b1);
    tick();
    tick();
    tick();
    check_b("t1_w3_blocked", m.ready, 1'b0);
    IOACT = 1'b1;
    tick();
    IOACT = 1'b0;
    tick();
    check_b("t1_w3_pop_ready", m.ready, 1'b0);
    check_b("t1_w3_pop_full", m.full, 1'b0);
    check_v("t1_w3_pop_head", 32'(m.ioa), 32'h2C0001);
    tick();
    check_b("t1_w3_ready", m.ready, 1'b1);
    check_b("t1_w3_full", m.full, 1'b1);
    as_end();

    // T2: two posted writes then a read; master serves in FIFO order
    do_reset();
    post_write(23'h2C0000, 16'hAAAA);
    post_write(23'h2C0001, 16'hBBBB);
    as_start(1'b1, 23'h2FF800, 16'h0000);
    ds_on(1'b1, 1'b1);
    tick();
    check_b("t2_rd_wait", m.ready, 1'b0);
    serve("t2_w0", 1'b0, 23'h2C0000, 16'hAAAA, 1'b1, 1'b1, 16'h0000);
    serve("t2_w1", 1'b0, 23'h2C0001, 16'hBBBB, 1'b1, 1'b1, 16'h0000);
    check_b("t2_rd_still_wait", m.ready, 1'b0);
    serve("t2_rd", 1'b1, 23'h2FF800, 16'h0000, 1'b1, 1'b1, 16'hA5C3);
    check_b("t2_rd_ready", m.ready, 1'b1);
    check_v("t2_rddata", 32'(m.rddata), 32'hA5C3);
    as_end();
    check_v("t2_rddata_hold", 32'(m.rddata), 32'hA5C3);

    // T4: reset while the master is in ACT with two entries queued
    post_write(23'h2C0010, 16'h0F0F);
    post_write(23'h2C0011, 16'hF0F0);
    IOACT = 1'b1;
    tick();
    check_b("t4_pre_full", m.full, 1'b1);
    nRES = 1'b0;
    #1;
    check_b("t4_rst_ready", m.ready, 1'b1);
    check_b("t4_rst_ioreq", m.ioreq, 1'b0);
    check_b("t4_rst_empty", m.empty, 1'b1);
    check_b("t4_rst_full", m.full, 1'b0);
    check_v("t4_rst_ioa", 32'(m.ioa), 32'h0);
    check_v("t4_rst_iod", 32'(m.iod), 32'h0);
    check_v("t4_rst_rddata", 32'(m.rddata), 32'h0);
    IOACT = 1'b0;
    tick();
    nRES = 1'b1;
    tick();
    tick();
    tick();
    check_b("t4_post_ioreq", m.ioreq, 1'b0);
    check_b("t4_post_empty", m.empty, 1'b1);

    // T5: data strobes on a cycle that does not select IO
    ASActive = 1'b1;
    IOCS     = 1'b0;
    nWE_FSB  = 1'b0;
    A_FSB    = 23'h2C0020;
    D_FSB    = 16'h5555;
    nLDS_FSB = 1'b0;
    nUDS_FSB = 1'b0;
    tick();
    tick();
    check_b("t5_ready", m.ready, 1'b1);
    check_b("t5_empty", m.empty, 1'b1);
    as_end();
    check_b("t5_empty_after", m.empty, 1'b1);

    // T3: non-posting write completes only after the IO bus cycle
    sel = 2'd1;
    do_reset();
    as_start(1'b0, 23'h2C0000, 16'h1234);
    ds_on(1'b1, 1'b1);
    tick();
    check_b("t3_taken_wait", m.ready, 1'b0);
    begin
      int n;
      n = 0;
      while (!m.ioreq && n < 50) begin
        tick();
        n++;
      end
    end
    check_b("t3_ioreq", m.ioreq, 1'b1);
    check_v("t3_iod", 32'(m.iod), 32'h1234);
    check_b("t3_iol", m.iol, 1'b1);
    check_b("t3_iou", m.iou, 1'b1);
    tick();
    tick();
    tick();
    check_b("t3_req_wait", m.ready, 1'b0);
    IOACT = 1'b1;
    tick();
    check_b("t3_act_wait", m.ready, 1'b0);
    IOACT = 1'b0;
    tick();
    check_b("t3_ready", m.ready, 1'b1);
    as_end();

    // T6: DEPTH=4, ten upper-byte writes through pointer wrap
    sel = 2'd2;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      as_start(1'b0, 23'(k), 16'(16'h0100 + k));
      ds_on(1'b0, 1'b1);
      tick();
      check_b("t6_fill_ready", m.ready, 1'b1);
      check_b("t6_fill_full", m.full, (k == 3));
      as_end();
    end
    for (int k = 4; k < 10; k++) begin
      as_start(1'b0, 23'(k), 16'(16'h0100 + k));
      ds_on(1'b0, 1'b1);
      check_b("t6_blk_ready", m.ready, 1'b0);
      serve("t6_mid", 1'b0, 23'(k - 4), 16'(16'h0100 + k - 4), 1'b0, 1'b1, 16'h0000);
      check_b("t6_mid_notfull", m.full, 1'b0);
      tick();
      check_b("t6_mid_full", m.full, 1'b1);
      check_b("t6_mid_ready", m.ready, 1'b1);
      as_end();
    end
    for (int k = 6; k < 10; k++) begin
      serve("t6_drain", 1'b0, 23'(k), 16'(16'h0100 + k), 1'b0, 1'b1, 16'h0000);
      check_b("t6_drain_full", m.full, 1'b0);
    end
    check_b("t6_empty", m.empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
